// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Front-end for the board push-buttons. Every channel is an identical,
// independent copy of:
//   raw pin -> synchroniser -> debounce filter -> registered level
//                                             -> press / release strobes
//                                             -> hold-to-auto-repeat strobes
//
// Ports
//   clk            in   1          system clock (single domain)
//   rst_n          in   1          asynchronous, active-low reset
//   btn_raw        in   N_BTN      raw button pins, asynchronous, 1 = pressed
//   btn_level      out  N_BTN      debounced level, 1 = pressed
//   btn_press      out  N_BTN      1-cycle strobe on debounced 0->1
//   btn_release    out  N_BTN      1-cycle strobe on debounced 1->0
//   btn_repeat     out  N_BTN      1-cycle auto-repeat strobe while held
//   dbg_rpt_state  out  2*N_BTN    repeat FSM state of each channel,
//                                  channel i at [2*i +: 2]
//                                  (0 = IDLE, 1 = HOLD, 2 = RPT)
//
// Handshake: there is none. Strobes are fire-and-forget single-cycle pulses
// with no ready/acknowledge; a consumer must sample them on every clock.
//
// All outputs are registered; nothing from btn_raw reaches an output
// without passing through the synchroniser and the output flops.
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int N_BTN           = 5,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 1,
  parameter int HOLD_CYCLES     = 64,
  parameter int REPEAT_CYCLES   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_BTN-1:0]   btn_raw,
  output logic [N_BTN-1:0]   btn_level,
  output logic [N_BTN-1:0]   btn_press,
  output logic [N_BTN-1:0]   btn_release,
  output logic [N_BTN-1:0]   btn_repeat,
  output logic [2*N_BTN-1:0] dbg_rpt_state
);

  // One counter width serves every per-channel counter. The counters are
  // cleared by the state rules before they can reach their maximum, so
  // they never wrap.
  localparam int MAX_AB = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_C  = (MAX_AB > REPEAT_CYCLES) ? MAX_AB : REPEAT_CYCLES;
  localparam int CW     = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] RPT_LAST  = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;

    logic [CW-1:0]          db_cnt_q, db_cnt_d;
    logic                   level_q, level_d;
    logic                   toggle;

    logic                   press_q, press_d;
    logic                   release_q, release_d;
    logic                   repeat_q, repeat_d;

    rpt_state_e             state_q, state_d;
    logic [CW-1:0]          rpt_cnt_q, rpt_cnt_d;

    // -------------------------------------------------------------------
    // Synchroniser: sync_q[0] is the metastability-catching flop, the
    // last stage is the first value the rest of the channel may look at.
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_raw[i]};
      end
    end

    assign s = sync_q[SYNC_STAGES-1];

    // -------------------------------------------------------------------
    // Debounce: count consecutive cycles in which the synchronised input
    // disagrees with the accepted level. Any agreeing cycle restarts the
    // count, so a bounce shorter than DEBOUNCE_CYCLES never gets through.
    // The level flips on the cycle the count would reach DEBOUNCE_CYCLES.
    // -------------------------------------------------------------------
    always_comb begin
      db_cnt_d = '0;
      level_d  = level_q;
      toggle   = 1'b0;
      if (s != level_q) begin
        if (db_cnt_q == DB_LAST) begin
          toggle  = 1'b1;
          level_d = ~level_q;
        end else begin
          db_cnt_d = db_cnt_q + CNT_ONE;
        end
      end
    end

    // Strobes are registered alongside the level so they show up in the
    // same cycle the level first carries its new value.
    assign press_d   = toggle & ~level_q;
    assign release_d = toggle &  level_q;

    // -------------------------------------------------------------------
    // Auto-repeat FSM. Entering HOLD on the press cycle with a cleared
    // counter places the first repeat exactly HOLD_CYCLES after the press
    // strobe, so it can never coincide with it. A release wins over a
    // repeat that would otherwise fall in the same cycle.
    // -------------------------------------------------------------------
    always_comb begin
      state_d   = state_q;
      rpt_cnt_d = rpt_cnt_q;
      repeat_d  = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          rpt_cnt_d = '0;
          if ((REPEAT_EN != 0) && press_d) begin
            state_d = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (release_d) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == HOLD_LAST) begin
            repeat_d  = 1'b1;
            state_d   = ST_RPT;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_ONE;
          end
        end
        ST_RPT: begin
          if (release_d) begin
            state_d   = ST_IDLE;
            rpt_cnt_d = '0;
          end else if (rpt_cnt_q == RPT_LAST) begin
            repeat_d  = 1'b1;
            rpt_cnt_d = '0;
          end else begin
            rpt_cnt_d = rpt_cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d   = ST_IDLE;
          rpt_cnt_d = '0;
        end
      endcase
    end

    // -------------------------------------------------------------------
    // Channel state registers
    // -------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        db_cnt_q  <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        repeat_q  <= 1'b0;
        state_q   <= ST_IDLE;
        rpt_cnt_q <= '0;
      end else begin
        db_cnt_q  <= db_cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        repeat_q  <= repeat_d;
        state_q   <= state_d;
        rpt_cnt_q <= rpt_cnt_d;
      end
    end

    assign btn_level[i]            = level_q;
    assign btn_press[i]            = press_q;
    assign btn_release[i]          = release_q;
    assign btn_repeat[i]           = repeat_q;
    assign dbg_rpt_state[2*i +: 2] = state_q;

  end : g_ch

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//
// Two instances share clock and raw inputs: u_dut (auto-repeat on) and
// u_dut_nr (auto-repeat off). A background reference model derives the
// expected outputs every cycle from the raw input history; directed table
// entries and hand sequences check timing corners on top of that.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N        = 5;
  localparam int SYNC     = 2;
  localparam int DEB      = 16;
  localparam int HOLD     = 64;
  localparam int RPT      = 16;
  localparam int HIST_MAX = 20000;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [N-1:0]   btn_raw;
  logic [N-1:0]   btn_level, btn_press, btn_release, btn_repeat;
  logic [2*N-1:0] dbg_state;
  logic [N-1:0]   n_level, n_press, n_release, n_repeat;
  logic [2*N-1:0] n_dbg;

  button_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_EN(1), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
  ) u_dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
    .btn_repeat(btn_repeat), .dbg_rpt_state(dbg_state)
  );

  button_conditioner #(
    .N_BTN(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB),
    .REPEAT_EN(0), .HOLD_CYCLES(HOLD), .REPEAT_CYCLES(RPT)
  ) u_dut_nr (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw),
    .btn_level(n_level), .btn_press(n_press), .btn_release(n_release),
    .btn_repeat(n_repeat), .dbg_rpt_state(n_dbg)
  );

  // ---------------------------------------------------------------- counters
  int n_vec  = 0;
  int n_miss = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Level flips once the synchronised input has disagreed with it for DEB
  // consecutive cycles (checked over a window of the raw history). Repeats
  // are pure arithmetic on the distance from the press.
  logic [N-1:0] hist [0:HIST_MAX-1];
  int           k = 0;
  logic [N-1:0] m_level = '0;
  int           m_press_t [N];
  logic [N-1:0] exp_press = '0, exp_rel = '0, exp_rpt = '0;

  function automatic logic s_at(input int j, input int c);
    if (j - SYNC < 1) return 1'b0;
    return hist[j-SYNC][c];
  endfunction

  task automatic model_step();
    for (int c = 0; c < N; c++) begin
      logic win;
      int   d;
      win = 1'b1;
      exp_press[c] = 1'b0;
      exp_rel[c]   = 1'b0;
      exp_rpt[c]   = 1'b0;
      for (int j = k - DEB + 1; j <= k; j++)
        if (s_at(j, c) == m_level[c]) win = 1'b0;
      if (win) begin
        if (!m_level[c]) begin
          exp_press[c] = 1'b1;
          m_press_t[c] = k;
        end else begin
          exp_rel[c] = 1'b1;
        end
        m_level[c] = ~m_level[c];
      end else if (m_level[c]) begin
        d = k - m_press_t[c];
        if (d >= HOLD && ((d - HOLD) % RPT) == 0) exp_rpt[c] = 1'b1;
      end
    end
  endtask

  initial begin : model_chk
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        k = 0;
        m_level = '0; exp_press = '0; exp_rel = '0; exp_rpt = '0;
      end else begin
        k++;
        if (k >= HIST_MAX) begin
          $display("FAIL hist_overflow: got %0d, expected < %0d", k, HIST_MAX);
          $fatal(1, "history overflow");
        end
        hist[k] = btn_raw;
        model_step();
      end
      #1;
      check("m_level",   int'(btn_level),   int'(m_level));
      check("m_press",   int'(btn_press),   int'(exp_press));
      check("m_release", int'(btn_release), int'(exp_rel));
      check("m_repeat",  int'(btn_repeat),  int'(exp_rpt));
      check("nr_level",  int'(n_level),     int'(m_level));
      check("nr_press",  int'(n_press),     int'(exp_press));
      check("nr_release",int'(n_release),   int'(exp_rel));
      check("nr_repeat", int'(n_repeat),    0);
    end
  end

  // ---------------------------------------------------------------- driver / observer
  int           ec;
  int           cnt_press [N], cnt_rel [N], cnt_rpt [N];
  int           press_at [N], rel_at [N];
  int           cnt_rpt_nr;
  logic [N-1:0] first_vec;
  bit           sb_on = 1'b0;
  logic [N-1:0] exp_q [$];

  task automatic clear_counts();
    ec = 0; cnt_rpt_nr = 0; first_vec = '0;
    for (int c = 0; c < N; c++) begin
      cnt_press[c] = 0; cnt_rel[c] = 0; cnt_rpt[c] = 0;
      press_at[c] = 0; rel_at[c] = 0;
    end
  endtask

  task automatic observe();
    @(posedge clk);
    #1;
    ec++;
    for (int c = 0; c < N; c++) begin
      if (btn_press[c]) begin
        cnt_press[c]++;
        if (press_at[c] == 0) press_at[c] = ec;
      end
      if (btn_release[c]) begin
        cnt_rel[c]++;
        if (rel_at[c] == 0) rel_at[c] = ec;
      end
      if (btn_repeat[c]) cnt_rpt[c]++;
      if (n_repeat[c])   cnt_rpt_nr++;
    end
    if (btn_press != '0 && first_vec == '0) first_vec = btn_press;
    if (sb_on && btn_press != '0) begin
      if (exp_q.size() == 0) check("sb_extra_press", int'(btn_press), 0);
      else                   check("sb_press", int'(btn_press), int'(exp_q.pop_front()));
    end
  endtask

  task automatic cycle(input logic [N-1:0] raw_v);
    @(negedge clk);
    btn_raw = raw_v;
    observe();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    btn_raw = '0;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic int exp_repeats(input int h);
    return (h > HOLD) ? ((h - HOLD - 1) / RPT + 1) : 0;
  endfunction

  // ---------------------------------------------------------------- vector table
  typedef struct {
    int ch;
    int hold;         // raw held high for this many sampled edges
    int exp_press_at; // edge of press strobe, 0 = none
    int exp_rpts;
    int exp_rel_at;   // edge of release strobe, 0 = none
  } vec_t;

  vec_t tbl [9];

  // ---------------------------------------------------------------- test
  initial begin
    int           tmr [N];
    logic [N-1:0] rv;
    int           sweep_ch [4];
    int           sweep_n  [4];
    int           tot_press [N];

    tbl[0] = '{4, 400, 18, 21, 418};
    tbl[1] = '{1, 10,  0,  0,  0};
    tbl[2] = '{1, 15,  0,  0,  0};
    tbl[3] = '{2, 16,  18, 0,  34};
    tbl[4] = '{3, 200, 18, 9,  218};
    tbl[5] = '{0, 64,  18, 0,  82};
    tbl[6] = '{0, 65,  18, 1,  83};
    tbl[7] = '{2, 80,  18, 1,  98};
    tbl[8] = '{4, 81,  18, 2,  99};

    btn_raw = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("reset_level",   int'(btn_level),   0);
    check("reset_press",   int'(btn_press),   0);
    check("reset_release", int'(btn_release), 0);
    check("reset_repeat",  int'(btn_repeat),  0);
    check("reset_state",   int'(dbg_state),   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(5);

    // single-button pulses from the table
    for (int v = 0; v < 9; v++) begin
      int others;
      clear_counts();
      for (int e = 1; e <= tbl[v].hold + 40; e++)
        cycle((e <= tbl[v].hold) ? (N'(1) << tbl[v].ch) : '0);
      others = 0;
      for (int c = 0; c < N; c++)
        if (c != tbl[v].ch) others += cnt_press[c] + cnt_rel[c] + cnt_rpt[c];
      check($sformatf("tbl%0d_press_at", v), press_at[tbl[v].ch], tbl[v].exp_press_at);
      check($sformatf("tbl%0d_npress", v), cnt_press[tbl[v].ch], (tbl[v].exp_press_at != 0) ? 1 : 0);
      check($sformatf("tbl%0d_repeats", v), cnt_rpt[tbl[v].ch], tbl[v].exp_rpts);
      check($sformatf("tbl%0d_rel_at", v), rel_at[tbl[v].ch], tbl[v].exp_rel_at);
      check($sformatf("tbl%0d_others", v), others, 0);
      check($sformatf("tbl%0d_nr_repeats", v), cnt_rpt_nr, 0);
    end

    // bounce on channel 1, then held
    clear_counts();
    for (int e = 1; e <= 10; e++) cycle(5'b00010);
    for (int e = 1; e <= 3; e++)  cycle(5'b00000);
    for (int e = 1; e <= 10; e++) cycle(5'b00010);
    check("bounce_no_press", cnt_press[1], 0);
    check("bounce_no_release", cnt_rel[1], 0);
    for (int e = 24; e <= 50; e++) cycle(5'b00010);
    check("bounce_press_at", press_at[1], 14 + SYNC + DEB - 1);
    check("bounce_npress", cnt_press[1], 1);
    idle(40);

    // simultaneous and staggered presses on channels 0 and 2
    clear_counts();
    for (int e = 1; e <= 40; e++) cycle(5'b00101);
    check("simul_vec", int'(first_vec), 5'b00101);
    check("simul_ch0_at", press_at[0], 18);
    check("simul_ch2_at", press_at[2], 18);
    idle(40);
    clear_counts();
    for (int e = 1; e <= 50; e++) cycle((e >= 4) ? 5'b00101 : 5'b00001);
    check("stagger_ch0_at", press_at[0], 18);
    check("stagger_gap", press_at[2] - press_at[0], 3);
    idle(40);

    // reset during HOLD on channel 2, button kept held
    clear_counts();
    for (int e = 1; e <= 38; e++) cycle(5'b00100);
    check("hold_press_at", press_at[2], 18);
    check("hold_state_ch2", int'(dbg_state[5:4]), 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("async_level",   int'(btn_level),   0);
    check("async_press",   int'(btn_press),   0);
    check("async_release", int'(btn_release), 0);
    check("async_repeat",  int'(btn_repeat),  0);
    check("async_state",   int'(dbg_state),   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    clear_counts();
    observe();
    for (int e = 2; e <= 40; e++) cycle(5'b00100);
    check("rehold_press_at", press_at[2], 18);
    check("rehold_npress", cnt_press[2], 1);
    idle(40);

    // direction sweep with scoreboard: D x5, U x2, R x5, L x5
    do_reset();
    sweep_ch = '{4, 2, 3, 1};
    sweep_n  = '{5, 2, 5, 5};
    for (int c = 0; c < N; c++) tot_press[c] = 0;
    clear_counts();
    sb_on = 1'b1;
    for (int s = 0; s < 4; s++) begin
      for (int p = 0; p < sweep_n[s]; p++) begin
        exp_q.push_back(N'(1) << sweep_ch[s]);
        tot_press[sweep_ch[s]]++;
        for (int e = 0; e < 400; e++) cycle(N'(1) << sweep_ch[s]);
        idle(400);
      end
    end
    sb_on = 1'b0;
    check("sb_leftover", exp_q.size(), 0);
    for (int c = 0; c < N; c++) begin
      check($sformatf("sweep_press_ch%0d", c),   cnt_press[c], tot_press[c]);
      check($sformatf("sweep_release_ch%0d", c), cnt_rel[c],   tot_press[c]);
      check($sformatf("sweep_repeat_ch%0d", c),  cnt_rpt[c],   tot_press[c] * exp_repeats(400));
    end

    // randomized toggling with a mid-run reset, checked by the model
    do_reset();
    rv = '0;
    for (int c = 0; c < N; c++) tmr[c] = 0;
    for (int t = 0; t < 4000; t++) begin
      if (t == 2000) begin
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      for (int c = 0; c < N; c++) begin
        if (tmr[c] == 0) begin
          rv[c]  = ~rv[c];
          tmr[c] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20))
                                               : int'($urandom_range(16, 150));
        end else begin
          tmr[c]--;
        end
      end
      cycle(rv);
    end
    idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
